fir_sequencer: RTL and testbench
================================

// Module: fir_sequencer
// PURPOSE
//  Sequences the 4-tap FIR datapath: steps muxControl, gates clearAccum and times enData per sample.
//  Also serially loads the 4x8-bit coefficient shift chain with non-overlapping shiftClk1/shiftClk2 pulses.
//  Sits beside the datapath; sample source and config host handshake with it directly.
// PARAMETERS
//  MULT_LAT   0  cycles from muxControl change to matching multResult at the datapath (legal 0..3)
//  SHIFT_DIV  1  clk cycles per shift-clock phase (legal 1..15)
// PORTS
//  clk          in   1   single system clock, all state on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  sample_valid in   1   new sample on datapath input a; held stable until accepted
//  sample_ready out  1   1-cycle pulse: sample taken this cycle (== enData)
//  cfg_valid    in   1   coefficient load request; cfg_coef held stable until cfg_ready
//  cfg_coef     in   32  {c3,c2,c1,c0}, 8 bits each
//  cfg_ready    out  1   1-cycle pulse on the last clk of a completed load
//  busy         out  1   1 whenever state != IDLE
//  y_valid      out  1   datapath y updated; set the cycle after enData, held until the next enData
//  muxControl   out  2   tap select to datapath
//  enData       out  1   delay-line shift + y-register enable to datapath
//  clearAccum   out  1   synchronous accumulator clear to datapath
//  shiftIn      out  1   serial coefficient bit
//  shiftClk1    out  1   coefficient chain master clock (registered, glitch-free)
//  shiftClk2    out  1   coefficient chain slave clock (registered, glitch-free)
// BEHAVIOUR
//  Reset: state IDLE; muxControl=0, enData=0, sample_ready=0, cfg_ready=0, y_valid=0.
//   Also at reset: shiftIn=0, shiftClk1=0, shiftClk2=0, clearAccum=1, busy=0.
//  States: IDLE, MAC, LOAD.
//  IDLE: clearAccum=1, muxControl=0. cfg_valid has priority over sample_valid when both are high.
//   cfg_valid -> LOAD; else sample_valid -> MAC with i=0.
//  MAC (i counts 0..MULT_LAT+3):
//   - muxControl = min(i,3)
//   - clearAccum = 1 while i < MULT_LAT, else 0
//   - enData = sample_ready = 1 only at i = MULT_LAT+3, then go to IDLE
//  Accumulator result and y:
//   - At enData, accumD = c0*a0+c1*a1+c2*a2+c3*a3 of the pre-shift window, so y latches that sum.
//   - The same edge shifts the held sample into a0.
//   - y therefore lags acceptance by one sample; the first y after reset is 0.
//  Spacing: at least one IDLE cycle between samples, so accumQ is cleared before the next tap 0.
//   Throughput is one sample per MULT_LAT+5 cycles.
//  cfg_valid arriving during MAC waits; MAC is never aborted.
//  LOAD, per bit: 4 phases of SHIFT_DIV cycles each.
//   - A: shiftClk1=1
//   - B: both clocks 0
//   - C: shiftClk2=1
//   - D: both clocks 0
//   - shiftIn changes only on entry to A and is stable through A..D. Clocks are never high together.
//  Bit order: cfg_coef[31] first, down to cfg_coef[0]; 32 bits total.
//   After the load c3 = cfg_coef[31:24] and c0 = cfg_coef[7:0].
//  Load timing: load takes 128*SHIFT_DIV cycles. cfg_ready pulses in the final D cycle, then IDLE.
//   sample_valid is ignored (sample_ready=0) during LOAD.
//  reset_n low mid-MAC or mid-LOAD: immediate return to reset values.
//   Coefficients are then undefined and cfg_ready does not pulse. Host must reload.
//  Counters: i is 3 bits; bit counter is 5 bits and wraps 31->0 only at load end.
//   Phase counter is 2 bits; divider counter is 4 bits.
// STRUCTURE
//  Package fir_seq_pkg: state_t enum {IDLE,MAC,LOAD}, phase_t {PH_A,PH_B,PH_C,PH_D}.
//   Package constants: NTAPS=4, COEF_W=8, CFG_BITS=NTAPS*COEF_W.
//  Sub-module shift_clk_gen #(SHIFT_DIV): start/done handshake, emits one A-B-C-D bit cycle.
//   It drives registered shiftClk1/shiftClk2. Top FSM owns the bit counter and the shiftIn register.
// TESTING
//  Test 1, reset:
//   - Stimulus: hold reset_n=0 with random inputs.
//   - Required: every output at its reset value. clearAccum=1; clocks low.
//  Test 2, single sample, MULT_LAT=0, coefs {4,3,2,1}:
//   - Stimulus: feed samples 1,2,3,4,5 back to back.
//   - Required: muxControl 0,1,2,3; enData at i=3; 6-cycle period.
//   - Required: y after 5th accept = 1*4+2*3+3*2+4*1 = 20.
//  Test 3, MULT_LAT=2 with a 2-stage multiplier model:
//   - Required: clearAccum high for i=0,1; enData at i=5; same y values as test 2.
//  Test 4, coefficient load, cfg_coef=32'hA5_0F_F0_3C, SHIFT_DIV=1:
//   - Required: 128 cycles; cfg_ready once; chain reads c3=A5, c2=0F, c1=F0, c0=3C.
//   - Required: shiftClk1 & shiftClk2 never both 1.
//  Test 5, collision:
//   - Stimulus: cfg_valid and sample_valid rise in the same IDLE cycle.
//   - Required: LOAD taken first; sample accepted MULT_LAT+4 cycles after the IDLE following cfg_ready.
//  Test 6, reset mid-load:
//   - Stimulus: reset_n low at bit 17, then reload.
//   - Required: clocks drop at once; no cfg_ready; reload then gives correct coefficients.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the 4-tap FIR sequencer.
// Holds the FSM state and shift-phase enums, the coefficient geometry and a tap-select helper.
// Imported by the interface, the shift-clock generator and the top.
package fir_seq_pkg;

  localparam int NTAPS    = 4;
  localparam int COEF_W   = 8;
  localparam int CFG_BITS = NTAPS * COEF_W;

  typedef enum logic [1:0] {IDLE, MAC, LOAD} state_t;
  typedef enum logic [1:0] {PH_A, PH_B, PH_C, PH_D} phase_t;

  // Tap select saturates at the last tap while the multiplier pipeline drains.
  function automatic logic [1:0] tap_sel(input logic [2:0] idx);
    return (idx > 3'd3) ? 2'd3 : idx[1:0];
  endfunction

endpackage

// File: rtl/fir_sequencer_if.sv
// Handshake and datapath-control bundle of the FIR sequencer.
// slave: the sequencer (takes sample/cfg requests, drives datapath and coefficient chain).
// master: the environment (sample source, config host, datapath/chain sink).
interface fir_sequencer_if;
  import fir_seq_pkg::*;

  logic                sample_valid;
  logic                sample_ready;
  logic                cfg_valid;
  logic [CFG_BITS-1:0] cfg_coef;
  logic                cfg_ready;
  logic                busy;
  logic                y_valid;
  logic [1:0]          muxControl;
  logic                enData;
  logic                clearAccum;
  logic                shiftIn;
  logic                shiftClk1;
  logic                shiftClk2;

  modport slave (
    input  sample_valid, cfg_valid, cfg_coef,
    output sample_ready, cfg_ready, busy, y_valid,
           muxControl, enData, clearAccum, shiftIn, shiftClk1, shiftClk2
  );

  modport master (
    output sample_valid, cfg_valid, cfg_coef,
    input  sample_ready, cfg_ready, busy, y_valid,
           muxControl, enData, clearAccum, shiftIn, shiftClk1, shiftClk2
  );

endinterface

// File: rtl/shift_clk_gen.sv
// Emits one A-B-C-D bit cycle of non-overlapping shift clocks per start pulse.
// Latency: shiftClk1 rises the cycle after start; a bit lasts 4*SHIFT_DIV cycles.
// Backpressure: none; start is only honoured idle or in the final cycle of a bit (done).
// Ports: clk, reset_n; start in; shiftClk1/shiftClk2 registered out;
//        done = current cycle is the last of the bit; done_next = next cycle will be.
module shift_clk_gen #(
  parameter int SHIFT_DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic shiftClk1,
  output logic shiftClk2,
  output logic done,
  output logic done_next
);
  import fir_seq_pkg::*;

  localparam logic [3:0] DIV_LAST = 4'(SHIFT_DIV - 1);

  logic       active, active_n;
  phase_t     phase, phase_n;
  logic [3:0] div, div_n;

  always_comb begin
    active_n = active;
    phase_n  = phase;
    div_n    = div;
    if (start) begin
      active_n = 1'b1;
      phase_n  = PH_A;
      div_n    = '0;
    end else if (active) begin
      if (div == DIV_LAST) begin
        div_n = '0;
        if (phase == PH_D) active_n = 1'b0;
        else               phase_n  = phase_t'(phase + 2'd1);
      end else begin
        div_n = div + 4'd1;
      end
    end
  end

  assign done_next = active_n && (phase_n == PH_D) && (div_n == DIV_LAST);

  // Clocks are decoded from the next phase and registered, so each is a clean
  // flop output and the two can never be high in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      phase     <= PH_A;
      div       <= '0;
      shiftClk1 <= 1'b0;
      shiftClk2 <= 1'b0;
      done      <= 1'b0;
    end else begin
      active    <= active_n;
      phase     <= phase_n;
      div       <= div_n;
      shiftClk1 <= active_n && (phase_n == PH_A);
      shiftClk2 <= active_n && (phase_n == PH_C);
      done      <= done_next;
    end
  end

endmodule

// File: rtl/fir_sequencer.sv
// Sequences the 4-tap FIR datapath per sample and serially loads the 32-bit coefficient chain.
// Latency: enData/sample_ready at MAC step MULT_LAT+3 (one sample per MULT_LAT+5 cycles); load 128*SHIFT_DIV cycles.
// Backpressure: requests are held by the source until sample_ready/cfg_ready; cfg waits out a MAC, samples wait out a LOAD.
// Ports: clk, reset_n (async, active low); sif (slave modport) carries sample/cfg handshakes,
//        datapath controls muxControl/enData/clearAccum, y_valid, busy and the shiftIn/shiftClk1/shiftClk2 chain.
module fir_sequencer #(
  parameter int MULT_LAT  = 0,
  parameter int SHIFT_DIV = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  fir_sequencer_if.slave  sif
);
  import fir_seq_pkg::*;

  localparam logic [2:0] ML3    = 3'(MULT_LAT);
  localparam logic [2:0] I_LAST = 3'(MULT_LAT + 3);
  localparam logic [4:0] B_LAST = 5'(CFG_BITS - 1);

  state_t     state;
  logic [2:0] i;
  logic [2:0] i_nxt;
  logic [4:0] bitcnt;
  logic [4:0] bit_nxt;
  logic       last_bit;
  logic       gen_start, gen_done, gen_done_next;

  assign i_nxt    = i + 3'd1;
  assign bit_nxt  = bitcnt + 5'd1;
  assign last_bit = (bitcnt == B_LAST);

  // A new bit cycle starts on LOAD entry and in the final cycle of every bit but the last.
  assign gen_start = ((state == IDLE) && sif.cfg_valid) ||
                     ((state == LOAD) && gen_done && !last_bit);

  shift_clk_gen #(.SHIFT_DIV(SHIFT_DIV)) u_shift_clk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (gen_start),
    .shiftClk1 (sif.shiftClk1),
    .shiftClk2 (sif.shiftClk2),
    .done      (gen_done),
    .done_next (gen_done_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      i                <= '0;
      bitcnt           <= '0;
      sif.muxControl   <= 2'd0;
      sif.enData       <= 1'b0;
      sif.sample_ready <= 1'b0;
      sif.cfg_ready    <= 1'b0;
      sif.y_valid      <= 1'b0;
      sif.clearAccum   <= 1'b1;
      sif.shiftIn      <= 1'b0;
      sif.busy         <= 1'b0;
    end else begin
      sif.enData       <= 1'b0;
      sif.sample_ready <= 1'b0;
      sif.cfg_ready    <= 1'b0;
      // The datapath y register loads on the enData edge.
      if (sif.enData) sif.y_valid <= 1'b1;

      unique case (state)
        IDLE: begin
          i              <= '0;
          sif.muxControl <= 2'd0;
          sif.clearAccum <= 1'b1;
          if (sif.cfg_valid) begin
            state       <= LOAD;
            sif.busy    <= 1'b1;
            bitcnt      <= '0;
            sif.shiftIn <= sif.cfg_coef[CFG_BITS-1];
          end else if (sif.sample_valid) begin
            state          <= MAC;
            sif.busy       <= 1'b1;
            sif.clearAccum <= (ML3 != 3'd0);
          end
        end

        MAC: begin
          if (i == I_LAST) begin
            state          <= IDLE;
            sif.busy       <= 1'b0;
            sif.muxControl <= 2'd0;
            sif.clearAccum <= 1'b1;
          end else begin
            i              <= i_nxt;
            sif.muxControl <= tap_sel(i_nxt);
            // Hold the accumulator clear until the first product reaches it.
            sif.clearAccum <= (i_nxt < ML3);
            if (i_nxt == I_LAST) begin
              sif.enData       <= 1'b1;
              sif.sample_ready <= 1'b1;
              sif.y_valid      <= 1'b0;
            end
          end
        end

        LOAD: begin
          if (gen_done) begin
            if (last_bit) begin
              state    <= IDLE;
              sif.busy <= 1'b0;
              bitcnt   <= '0;
            end else begin
              bitcnt      <= bit_nxt;
              // MSB first: bit index 31-n is the ones' complement of n.
              sif.shiftIn <= sif.cfg_coef[~bit_nxt];
            end
          end
          if (gen_done_next && last_bit) sif.cfg_ready <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
module tb_fir_sequencer;
  import fir_seq_pkg::*;

  localparam int ML0 = 0;
  localparam int SD0 = 1;
  localparam int ML1 = 2;
  localparam int SD1 = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fir_sequencer_if i0 ();
  fir_sequencer_if i1 ();

  fir_sequencer #(.MULT_LAT(ML0), .SHIFT_DIV(SD0)) dut0 (.clk(clk), .reset_n(reset_n), .sif(i0));
  fir_sequencer #(.MULT_LAT(ML1), .SHIFT_DIV(SD1)) dut1 (.clk(clk), .reset_n(reset_n), .sif(i1));

  logic        samp_vld [2];
  logic        cfg_vld  [2];
  logic [31:0] cfg_dat  [2];
  logic [1:0]  mux  [2];
  logic        clr  [2];
  logic        en   [2];
  logic        sin  [2];
  logic        sc1  [2];
  logic        sc2  [2];
  logic        srdy [2];
  logic        crdy [2];
  logic        bsy  [2];
  logic        yv   [2];

  assign i0.sample_valid = samp_vld[0];
  assign i0.cfg_valid    = cfg_vld[0];
  assign i0.cfg_coef     = cfg_dat[0];
  assign i1.sample_valid = samp_vld[1];
  assign i1.cfg_valid    = cfg_vld[1];
  assign i1.cfg_coef     = cfg_dat[1];

  assign mux[0]  = i0.muxControl;   assign mux[1]  = i1.muxControl;
  assign clr[0]  = i0.clearAccum;   assign clr[1]  = i1.clearAccum;
  assign en[0]   = i0.enData;       assign en[1]   = i1.enData;
  assign sin[0]  = i0.shiftIn;      assign sin[1]  = i1.shiftIn;
  assign sc1[0]  = i0.shiftClk1;    assign sc1[1]  = i1.shiftClk1;
  assign sc2[0]  = i0.shiftClk2;    assign sc2[1]  = i1.shiftClk2;
  assign srdy[0] = i0.sample_ready; assign srdy[1] = i1.sample_ready;
  assign crdy[0] = i0.cfg_ready;    assign crdy[1] = i1.cfg_ready;
  assign bsy[0]  = i0.busy;         assign bsy[1]  = i1.busy;
  assign yv[0]   = i0.y_valid;      assign yv[1]   = i1.y_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_en = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Datapath and coefficient-chain model driven by each DUT's control outputs.
  // Coefficients {c3,c2,c1,c0} = {4,3,2,1}.
  int          coef [4] = '{1, 2, 3, 4};
  int          mlat [2] = '{ML0, ML1};
  int          sdiv [2] = '{SD0, SD1};
  int          a_in [2];
  int          dl   [2][4];
  int          pipe [2][4];
  int          accq [2];
  int          y    [2];
  logic        m1   [2];
  logic [31:0] chain[2];
  logic        p1   [2];
  logic        p2   [2];
  int          prod_v, mres_v, accd_v;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        accq[k] = 0;
        y[k]    = 0;
        p1[k]   = 1'b0;
        p2[k]   = 1'b0;
        for (int s = 0; s < 4; s++) begin
          dl[k][s]   = 0;
          pipe[k][s] = 0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        prod_v = coef[mux[k]] * dl[k][mux[k]];
        mres_v = (mlat[k] == 0) ? prod_v : pipe[k][mlat[k]-1];
        for (int s = 3; s > 0; s--) pipe[k][s] = pipe[k][s-1];
        pipe[k][0] = prod_v;
        accd_v  = accq[k] + mres_v;
        accq[k] = clr[k] ? 0 : accd_v;
        if (en[k]) begin
          y[k] = accd_v;
          for (int s = 3; s > 0; s--) dl[k][s] = dl[k][s-1];
          dl[k][0] = a_in[k];
        end
        if (sc1[k] && !p1[k]) m1[k] = sin[k];
        if (sc2[k] && !p2[k]) chain[k] = {chain[k][30:0], m1[k]};
        p1[k] = sc1[k];
        p2[k] = sc2[k];
      end
    end
  end

  logic overlap_seen = 1'b0;
  always @(negedge clk)
    if ((i0.shiftClk1 && i0.shiftClk2) || (i1.shiftClk1 && i1.shiftClk2)) overlap_seen <= 1'b1;

  // Offers one sample from an IDLE negedge and checks the MAC timeline cycle by cycle.
  task automatic run_sample(input int k, input int val, input int y_exp, input bit first);
    int ml;
    ml = mlat[k];
    a_in[k] = val;
    samp_vld[k] = 1'b1;
    chk("idle_busy", int'(bsy[k]), 0);
    chk("idle_clr", int'(clr[k]), 1);
    chk("idle_mux", int'(mux[k]), 0);
    for (int j = 0; j <= ml + 3; j++) begin
      @(negedge clk);
      chk("mac_busy", int'(bsy[k]), 1);
      chk("mac_mux", int'(mux[k]), (j > 3) ? 3 : j);
      chk("mac_clr", int'(clr[k]), int'(j < ml));
      chk("mac_en", int'(en[k]), int'(j == ml + 3));
      chk("mac_srdy", int'(srdy[k]), int'(j == ml + 3));
    end
    chk("y_valid_at_en", int'(yv[k]), 0);
    if (!first) chk("sample_period", cyc - last_en, ml + 5);
    last_en = cyc;
    @(posedge clk);
    #1 samp_vld[k] = 1'b0;
    @(negedge clk);
    chk("y_valid_after_en", int'(yv[k]), 1);
    chk("y_value", y[k], y_exp);
    chk("back_to_idle", int'(bsy[k]), 0);
  endtask

  // Full coefficient load from an IDLE negedge; host drops cfg_valid on cfg_ready.
  task automatic do_load(input int k, input logic [31:0] c);
    int n, nbusy, nrdy, rdy_at, len;
    n = 0; nbusy = 0; nrdy = 0; rdy_at = -1;
    len = 128 * sdiv[k];
    cfg_dat[k] = c;
    cfg_vld[k] = 1'b1;
    for (int t = 0; t < len + 4; t++) begin
      @(negedge clk);
      n++;
      if (bsy[k]) nbusy++;
      if (crdy[k]) begin
        nrdy++;
        rdy_at = n;
        cfg_vld[k] = 1'b0;
      end
    end
    cfg_vld[k] = 1'b0;
    chk("load_busy_cycles", nbusy, len);
    chk("load_cfg_ready_count", nrdy, 1);
    chk("load_cfg_ready_cycle", rdy_at, len);
    chk("load_idle_after", int'(bsy[k]), 0);
  endtask

  typedef struct {
    int a;
    int y_exp;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int   n, hi, got, flag;

    vecs[0] = '{a: 1, y_exp: 0};
    vecs[1] = '{a: 2, y_exp: 1};
    vecs[2] = '{a: 3, y_exp: 4};
    vecs[3] = '{a: 4, y_exp: 10};
    vecs[4] = '{a: 5, y_exp: 20};

    for (int k = 0; k < 2; k++) begin
      samp_vld[k] = 1'b0;
      cfg_vld[k]  = 1'b0;
      cfg_dat[k]  = '0;
      a_in[k]     = 0;
    end

    // Test 1: reset with random inputs
    reset_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        samp_vld[k] = 1'($urandom_range(0, 1));
        cfg_vld[k]  = 1'($urandom_range(0, 1));
        cfg_dat[k]  = $urandom;
      end
    end
    @(negedge clk);
    chk("rst_sample_ready", int'(srdy[0]), 0);
    chk("rst_cfg_ready", int'(crdy[0]), 0);
    chk("rst_busy", int'(bsy[0]), 0);
    chk("rst_y_valid", int'(yv[0]), 0);
    chk("rst_muxControl", int'(mux[0]), 0);
    chk("rst_enData", int'(en[0]), 0);
    chk("rst_clearAccum", int'(clr[0]), 1);
    chk("rst_shiftIn", int'(sin[0]), 0);
    chk("rst_shiftClk1", int'(sc1[0]), 0);
    chk("rst_shiftClk2", int'(sc2[0]), 0);
    chk("rst_busy_ml2", int'(bsy[1]), 0);
    chk("rst_clearAccum_ml2", int'(clr[1]), 1);
    for (int k = 0; k < 2; k++) begin
      samp_vld[k] = 1'b0;
      cfg_vld[k]  = 1'b0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Test 2: back-to-back samples, MULT_LAT=0
    for (int v = 0; v < 5; v++) run_sample(0, vecs[v].a, vecs[v].y_exp, v == 0);

    // Test 3: same samples, MULT_LAT=2 with pipelined multiplier model
    for (int v = 0; v < 5; v++) run_sample(1, vecs[v].a, vecs[v].y_exp, v == 0);

    // Test 4: coefficient loads
    do_load(0, 32'hA50FF03C);
    chk("chain_c3", int'(chain[0][31:24]), 8'hA5);
    chk("chain_c2", int'(chain[0][23:16]), 8'h0F);
    chk("chain_c1", int'(chain[0][15:8]), 8'hF0);
    chk("chain_c0", int'(chain[0][7:0]), 8'h3C);
    do_load(1, 32'hC35A817E);
    chk("chain_div2", int'(chain[1]), int'(32'hC35A817E));
    chk("no_clk_overlap", int'(overlap_seen), 0);

    // Test 5: cfg and sample collide in the same IDLE cycle
    cfg_dat[0] = 32'h04030201;
    cfg_vld[0] = 1'b1;
    a_in[0] = 6;
    samp_vld[0] = 1'b1;
    n = 0; got = 0; flag = 0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (srdy[0]) flag = 1;
      if (crdy[0]) begin
        got = 1;
        cfg_vld[0] = 1'b0;
      end
    end
    cfg_vld[0] = 1'b0;
    chk("coll_cfg_ready", got, 1);
    chk("coll_load_first", n, 128);
    chk("coll_no_sample_in_load", flag, 0);
    @(negedge clk);
    chk("coll_idle_after_load", int'(bsy[0]), 0);
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (srdy[0]) got = 1;
    end
    chk("coll_accept_delay", n, ML0 + 4);
    @(posedge clk);
    #1 samp_vld[0] = 1'b0;
    @(negedge clk);
    chk("coll_y", y[0], 30);

    // Test 6: reset in the middle of a load, then reload
    cfg_dat[0] = 32'hDEADBEEF;
    cfg_vld[0] = 1'b1;
    n = 0; hi = 0; got = 0;
    while (hi < 18 && n < 200) begin
      @(negedge clk);
      n++;
      if (sc1[0]) hi++;
      if (crdy[0]) got = 1;
    end
    chk("midload_reach_bit17", hi, 18);
    reset_n = 1'b0;
    #1;
    chk("midload_clk1_drop", int'(sc1[0]), 0);
    chk("midload_clk2_drop", int'(sc2[0]), 0);
    chk("midload_busy_drop", int'(bsy[0]), 0);
    cfg_vld[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (crdy[0]) got = 1;
    end
    chk("midload_no_cfg_ready", got, 0);
    reset_n = 1'b1;
    @(negedge clk);
    do_load(0, 32'h12345678);
    chk("reload_chain", int'(chain[0]), int'(32'h12345678));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
